// File: rtl/card_slot_pkg.sv
// Shared definitions for the card slot scheduler: FSM states, card value limit
// and slot-count limit.
package card_slot_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      COMMIT = 2'd3
   } slotState_t;

   localparam int CARD_MAX  = 52;
   localparam int MAX_SLOTS = 16;
   localparam int IDX_W     = 4;

   // Values above the largest card id are shown as a blank slot.
   function automatic logic [31:0] clampCard(input logic [31:0] value);
      return (value > 32'(CARD_MAX)) ? 32'd0 : value;
   endfunction

endpackage

// File: rtl/card_slot_shadow.sv
// Staging/shadow storage for the displayed card slots: per-entry staging
// writes, single-cycle bulk commit into the shadow, asynchronous shadow read.
module card_slot_shadow
   import card_slot_pkg::*;
#(
   parameter int NUM_SLOTS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stageWe,
   input  logic [IDX_W-1:0] stageIdx,
   input  logic [31:0]      stageData,
   input  logic             commit,
   input  logic [IDX_W-1:0] rdIdx,
   output logic [31:0]      rdData
);

   localparam logic [IDX_W:0] SLOT_LIM = (IDX_W+1)'(NUM_SLOTS);

   // Arrays span the full slot limit so a 4-bit index always fits; entries at
   // or above NUM_SLOTS are never written and stay at their reset value.
   logic [31:0] staging [MAX_SLOTS];
   logic [31:0] shadow  [MAX_SLOTS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < MAX_SLOTS; k++) begin
            staging[k] <= '0;
         end
      end else if (stageWe) begin
         staging[stageIdx] <= stageData;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < MAX_SLOTS; k++) begin
            shadow[k] <= '0;
         end
      end else if (commit) begin
         for (int k = 0; k < MAX_SLOTS; k++) begin
            shadow[k] <= staging[k];
         end
      end
   end

   always_comb begin
      rdData = '0;
      if ({1'b0, rdIdx} < SLOT_LIM) begin
         rdData = shadow[rdIdx];
      end
   end

endmodule

// File: rtl/card_slot_scheduler.sv
// Per-frame card slot fetcher sharing one data-memory port with the CPU.
// Optional build macro CARD_SLOT_CLAMP_EN blanks fetched values above CARD_MAX.
module card_slot_scheduler
   import card_slot_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int BASE_ADDR = 16,
   parameter int ADDR_W    = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              screen_end,
   input  logic              cpu_req,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_ready,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic [3:0]        slot_sel,
   output logic [31:0]       slot_index,
   output logic              frame_valid,
   output logic              overrun
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

   slotState_t       state;
   slotState_t       nextState;
   logic [IDX_W-1:0] slotCnt;
   logic [IDX_W-1:0] nextCnt;
   logic             stageWe;
   logic [IDX_W-1:0] stageIdx;
   logic [31:0]      stageData;
   logic             commit;
   logic             frameValidQ;
   logic             overrunQ;
   logic             cpuRvalidQ;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         slotCnt <= '0;
      end else begin
         state   <= nextState;
         slotCnt <= nextCnt;
      end
   end

   // Read data lags the address by one cycle, so FETCH cycle i captures
   // slot i-1 and DRAIN picks up the last slot.
   always_comb begin
      nextState = state;
      nextCnt   = '0;
      stageWe   = 1'b0;
      stageIdx  = slotCnt - IDX_W'(1);
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (screen_end) begin
               nextState = FETCH;
            end
         end
         FETCH: begin
            stageWe = (slotCnt != '0);
            if (slotCnt == LAST_IDX) begin
               nextState = DRAIN;
            end else begin
               nextCnt = slotCnt + IDX_W'(1);
            end
         end
         DRAIN: begin
            stageWe   = 1'b1;
            stageIdx  = LAST_IDX;
            nextState = COMMIT;
         end
         COMMIT: begin
            commit    = 1'b1;
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   assign cpu_ready = (state != FETCH);

   always_comb begin
      mem_addr  = cpu_addr;
      mem_wen   = cpu_req & cpu_wen;
      mem_wdata = cpu_wdata;
      if (!cpu_ready) begin
         mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(slotCnt);
         mem_wen   = 1'b0;
         mem_wdata = '0;
      end
   end

`ifdef CARD_SLOT_CLAMP_EN
   assign stageData = clampCard(mem_rdata);
`else
   assign stageData = mem_rdata;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frameValidQ <= 1'b0;
         overrunQ    <= 1'b0;
         cpuRvalidQ  <= 1'b0;
      end else begin
         if (commit) begin
            frameValidQ <= 1'b1;
         end
         if (screen_end && (state != IDLE)) begin
            overrunQ <= 1'b1;
         end
         cpuRvalidQ <= cpu_req & ~cpu_wen & cpu_ready;
      end
   end

   // Read return comes straight from the memory's one-cycle-late data.
   assign cpu_rdata   = cpuRvalidQ ? mem_rdata : 32'd0;
   assign cpu_rvalid  = cpuRvalidQ;
   assign frame_valid = frameValidQ;
   assign overrun     = overrunQ;

   card_slot_shadow #(
      .NUM_SLOTS(NUM_SLOTS)
   ) uShadow (
      .clk      (clk),
      .reset    (reset),
      .stageWe  (stageWe),
      .stageIdx (stageIdx),
      .stageData(stageData),
      .commit   (commit),
      .rdIdx    (slot_sel),
      .rdData   (slot_index)
   );

endmodule

// File: tb/tb_card_slot_scheduler.sv
// Scoreboard bench for card_slot_scheduler: expected memory accesses and CPU
// read returns are queued by the stimulus and checked by a negedge monitor.
module tb_card_slot_scheduler;

   localparam int NS = 8;

   typedef struct {
      logic [11:0] addr;
      logic        wen;
      logic [31:0] wdata;
   } acc_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        screen_end = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_wen = 1'b0;
   logic [11:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        cpu_rvalid;
   logic [11:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [3:0]  slot_sel = '0;
   logic [31:0] slot_index;
   logic        frame_valid;
   logic        overrun;

   logic [31:0] mem [0:4095];
   logic        preloaded = 1'b0;

   acc_t        expAcc[$];
   logic [31:0] expRd[$];
   int          nTests = 0;
   int          nFail = 0;

   always #10 clk = ~clk;

   card_slot_scheduler #(.NUM_SLOTS(NS), .BASE_ADDR(16), .ADDR_W(12)) dut (
      .clk        (clk),
      .reset      (reset),
      .screen_end (screen_end),
      .cpu_req    (cpu_req),
      .cpu_wen    (cpu_wen),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ready  (cpu_ready),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .mem_addr   (mem_addr),
      .mem_wen    (mem_wen),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .slot_sel   (slot_sel),
      .slot_index (slot_index),
      .frame_valid(frame_valid),
      .overrun    (overrun)
   );

   // Synchronous memory: read data valid one cycle after the address.
   always @(posedge clk) begin
      if (!preloaded) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
         for (int i = 0; i < NS; i++) mem[16+i] <= 32'(i + 1);
         mem[5] <= 32'hABCD;
         preloaded <= 1'b1;
      end else if (mem_wen) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkSlot(input int k, input logic [31:0] exp);
      slot_sel = 4'(k);
      #1;
      check($sformatf("slot_index[%0d]", k), slot_index, exp);
   endtask

   task automatic pushFetch(input int n);
      for (int i = 0; i < n; i++) expAcc.push_back('{addr: 12'(16 + i), wen: 1'b0, wdata: 32'd0});
   endtask

   task automatic screenPulse();
      screen_end = 1'b1;
      tick();
      screen_end = 1'b0;
   endtask

   // Monitor: every memory access and every read return is matched in order.
   always @(negedge clk) begin
      acc_t e;
      logic [31:0] r;
      if (reset) begin
         if (!cpu_ready || cpu_req) begin
            if (expAcc.size() == 0) begin
               nTests++;
               nFail++;
               $display("FAIL acc_unexpected: got addr=%0d wen=%0b, required no access", mem_addr, mem_wen);
            end else begin
               e = expAcc.pop_front();
               check("acc_addr", {20'd0, mem_addr}, {20'd0, e.addr});
               check("acc_wen", {31'd0, mem_wen}, {31'd0, e.wen});
               if (e.wen) check("acc_wdata", mem_wdata, e.wdata);
            end
         end
         if (cpu_rvalid) begin
            if (expRd.size() == 0) begin
               nTests++;
               nFail++;
               $display("FAIL rvalid_unexpected: got rdata=%0h, required no rvalid", cpu_rdata);
            end else begin
               r = expRd.pop_front();
               check("cpu_rdata", cpu_rdata, r);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int waitCnt;

      // Reset state
      repeat (3) tick();
      check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
      check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      checkSlot(0, 32'd0);
      checkSlot(7, 32'd0);
      reset = 1'b1;
      repeat (2) tick();

      // Full frame fetch of words 16..23 = 1..8
      pushFetch(NS);
      screenPulse();
      for (int i = 0; i < NS; i++) begin
         check($sformatf("fetch_ready_c%0d", i), {31'd0, cpu_ready}, 32'd0);
         tick();
      end
      check("drain_ready", {31'd0, cpu_ready}, 32'd1);
      tick();
      check("commit_frame_valid", {31'd0, frame_valid}, 32'd0);
      checkSlot(0, 32'd0);
      tick();
      check("frame_valid_set", {31'd0, frame_valid}, 32'd1);
      for (int k = 0; k < NS; k++) checkSlot(k, 32'(k + 1));
      tick();
      checkSlot(8, 32'd0);
      checkSlot(15, 32'd0);
      check("overrun_clear", {31'd0, overrun}, 32'd0);

      // CPU read of address 5 in IDLE
      cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 12'd5;
      expAcc.push_back('{addr: 12'd5, wen: 1'b0, wdata: 32'd0});
      expRd.push_back(32'hABCD);
      tick();
      cpu_req = 1'b0;
      repeat (2) tick();

      // CPU write issued on FETCH cycle 3 is held until DRAIN
      pushFetch(NS);
      expAcc.push_back('{addr: 12'd17, wen: 1'b1, wdata: 32'd40});
      screenPulse();
      repeat (3) tick();
      cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 12'd17; cpu_wdata = 32'd40;
      waitCnt = 0;
      while (!cpu_ready && waitCnt < 20) begin
         tick();
         waitCnt++;
      end
      check("wr_held_cycles", 32'(waitCnt), 32'd5);
      tick();
      cpu_req = 1'b0; cpu_wen = 1'b0;
      tick();
      check("mem17_written", mem[17], 32'd40);
      checkSlot(1, 32'd2);
      checkSlot(0, 32'd1);

      // Second screen_end during FETCH sets overrun and starts nothing new
      pushFetch(NS);
      screenPulse();
      repeat (2) tick();
      screen_end = 1'b1;
      tick();
      screen_end = 1'b0;
      check("overrun_set", {31'd0, overrun}, 32'd1);
      repeat (7) tick();
      checkSlot(1, 32'd40);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("no_refetch_c%0d", i), {31'd0, cpu_ready}, 32'd1);
         tick();
      end
      check("overrun_sticky", {31'd0, overrun}, 32'd1);

      // Write word 18 = 60 in the same IDLE cycle as screen_end
      cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 12'd18; cpu_wdata = 32'd60;
      expAcc.push_back('{addr: 12'd18, wen: 1'b1, wdata: 32'd60});
      pushFetch(NS);
      screen_end = 1'b1;
      tick();
      screen_end = 1'b0;
      cpu_req = 1'b0; cpu_wen = 1'b0;
      check("same_cycle_fetch", {31'd0, cpu_ready}, 32'd0);
      repeat (10) tick();
`ifdef CARD_SLOT_CLAMP_EN
      checkSlot(2, 32'd0);
`else
      checkSlot(2, 32'd60);
`endif
      checkSlot(1, 32'd40);
      checkSlot(3, 32'd4);
      check("frame_valid_held", {31'd0, frame_valid}, 32'd1);

      // Reset on FETCH cycle 4
      pushFetch(4);
      screenPulse();
      repeat (4) tick();
      reset = 1'b0;
      #1;
      check("rst_mid_ready", {31'd0, cpu_ready}, 32'd1);
      tick();
      for (int k = 0; k < NS; k++) checkSlot(k, 32'd0);
      tick();
      check("rst_mid_frame_valid", {31'd0, frame_valid}, 32'd0);
      check("rst_mid_overrun", {31'd0, overrun}, 32'd0);
      check("rst_mid_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("post_rst_idle_c%0d", i), {31'd0, cpu_ready}, 32'd1);
         tick();
      end

      check("acc_queue_empty", 32'(expAcc.size()), 32'd0);
      check("rd_queue_empty", 32'(expRd.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
